act_maxpool2x2: RTL

ACT_MAXPOOL2X2 -- requirements
Module: act_maxpool2x2

---
 rtl/act_maxpool2x2_if.sv | 23 ++
 rtl/act_maxpool2x2.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/act_maxpool2x2_if.sv
// Streaming bus of the 2x2 max-pool stage: activation samples in, pooled results out.
interface act_maxpool2x2_if #(
  parameter int IDX_W = 4
) ();
  logic             en;
  logic             sof;
  logic             din_valid;
  logic [7:0]       din;
  logic             pool_valid;
  logic [7:0]       pool_out;
  logic [IDX_W-1:0] pool_idx;
  logic             frame_done;

  modport master (
    output en, sof, din_valid, din,
    input  pool_valid, pool_out, pool_idx, frame_done
  );

  modport slave (
    input  en, sof, din_valid, din,
    output pool_valid, pool_out, pool_idx, frame_done
  );
endinterface

// File: rtl/act_maxpool2x2.sv
// 2x2 max-pool over a raster activation stream: horizontal pair max on every odd
// column, even rows parked in a line buffer, combined with the odd row to emit.
module act_maxpool2x2 #(
  parameter int ROW_W      = 32,
  parameter int FRAME_ROWS = 32,
  parameter int IDX_W      = 4
) (
  input logic             clk,
  input logic             rst_n,
  act_maxpool2x2_if.slave bus
);

  localparam int COL_W  = $clog2(ROW_W);
  localparam int ROW_CW = $clog2(FRAME_ROWS);
  localparam int PAIRS  = ROW_W / 2;
  localparam int PAIR_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_W - 1);
  localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(FRAME_ROWS - 1);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } phase_t;

  phase_t state_reg, state_next;

  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_CW-1:0] row_reg, row_next;
  logic [7:0]        hold_reg, hold_next;
  logic              pool_valid_reg, pool_valid_next;
  logic              frame_done_reg, frame_done_next;
  logic [7:0]        pool_out_reg, pool_out_next;
  logic [IDX_W-1:0]  pool_idx_reg, pool_idx_next;

  logic              accept;
  logic              col_odd;
  logic              col_wrap;
  logic              fill_write;
  logic              emit_fire;
  logic [PAIR_W-1:0] pair_idx;
  logic [7:0]        pair_max;
  logic [7:0]        pool_max;

  logic [7:0]        linebuf [PAIRS];
  logic [7:0]        lb_rd_reg;

  assign accept   = bus.en & bus.din_valid;
  assign col_odd  = col_reg[0];
  assign col_wrap = (col_reg == COL_LAST);
  assign pair_idx = PAIR_W'(col_reg >> 1);

  // A sample that arrives with sof belongs to the new frame at col 0, so it
  // can never complete a pair of the old one.
  assign fill_write = accept & ~bus.sof & (state_reg == FILL) & col_odd;
  assign emit_fire  = accept & ~bus.sof & (state_reg == EMIT) & col_odd;

  assign pair_max = (bus.din > hold_reg) ? bus.din : hold_reg;
  assign pool_max = (lb_rd_reg > pair_max) ? lb_rd_reg : pair_max;

  // Row phase FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.sof) begin
      state_next = FILL;
    end else if (accept && col_wrap) begin
      state_next = (state_reg == FILL) ? EMIT : FILL;
    end
  end

  // Counters, hold register and output registers
  always_comb begin
    col_next        = col_reg;
    row_next        = row_reg;
    hold_next       = hold_reg;
    pool_valid_next = 1'b0;
    frame_done_next = 1'b0;
    pool_out_next   = pool_out_reg;
    pool_idx_next   = pool_idx_reg;

    if (bus.sof) begin
      col_next = '0;
      row_next = '0;
      if (accept) begin
        col_next  = COL_W'(1);
        hold_next = bus.din;
      end
    end else if (accept) begin
      if (col_wrap) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + ROW_CW'(1);
      end else begin
        col_next = col_reg + COL_W'(1);
      end

      if (!col_odd) begin
        hold_next = bus.din;
      end

      if (emit_fire) begin
        pool_valid_next = 1'b1;
        pool_out_next   = pool_max;
        pool_idx_next   = IDX_W'(pair_idx);
        frame_done_next = (row_reg == ROW_LAST) && col_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg        <= '0;
      row_reg        <= '0;
      hold_reg       <= '0;
      pool_valid_reg <= 1'b0;
      frame_done_reg <= 1'b0;
      pool_out_reg   <= '0;
      pool_idx_reg   <= '0;
    end else begin
      col_reg        <= col_next;
      row_reg        <= row_next;
      hold_reg       <= hold_next;
      pool_valid_reg <= pool_valid_next;
      frame_done_reg <= frame_done_next;
      pool_out_reg   <= pool_out_next;
      pool_idx_reg   <= pool_idx_next;
    end
  end

  // Line buffer with registered read. The address tracks col>>1, so the read
  // issued while the even column of a pair is current is ready for the odd one,
  // and stalls simply re-read the same entry.
  always_ff @(posedge clk) begin
    if (rst_n && fill_write) begin
      linebuf[pair_idx] <= pair_max;
    end
    lb_rd_reg <= linebuf[pair_idx];
  end

  assign bus.pool_valid = pool_valid_reg;
  assign bus.pool_out   = pool_out_reg;
  assign bus.pool_idx   = pool_idx_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
